// File: rtl/mem_rr_arbiter_pkg.sv
// Shared memory-bus constants, arbiter state encoding and a one-hot decode helper.
package mem_rr_arbiter_pkg;

  localparam int unsigned MEM_AW    = 18;
  localparam int unsigned MEM_DW    = 36;
  localparam int unsigned MAX_PORTS = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  // Index of the set bit in a one-hot vector; 0 when none is set.
  function automatic int unsigned onehot_index(input logic [MAX_PORTS-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_PORTS; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_rr_arbiter_if.sv
// Read/write/waitrequest memory bus, N ports wide, with flattened per-port fields.
interface mem_rr_arbiter_if
  import mem_rr_arbiter_pkg::*;
#(
  parameter int unsigned N  = 1,
  parameter int unsigned AW = MEM_AW,
  parameter int unsigned DW = MEM_DW
);

  logic [N*AW-1:0] address;
  logic [N-1:0]    write;
  logic [N-1:0]    read;
  logic [N*DW-1:0] writedata;
  logic [N*DW-1:0] readdata;
  logic [N-1:0]    waitrequest;

  modport master (
    output address, write, read, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, write, read, writedata,
    output readdata, waitrequest
  );

endinterface

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests by ptr, take the lowest, rotate back.
module rr_pick #(
  parameter int unsigned NPORTS = 4,
  parameter int unsigned PW     = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic [NPORTS-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic [NPORTS-1:0] gnt,
  output logic              valid
);

  logic [NPORTS-1:0] rot;
  logic [NPORTS-1:0] pri;
  logic              found;

  function automatic logic [PW-1:0] rot_idx(input int unsigned i, input logic [PW-1:0] p);
    return PW'((i + 32'(p)) % NPORTS);
  endfunction

  always_comb begin
    rot   = '0;
    pri   = '0;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      rot[i] = req[rot_idx(i, ptr)];
    end
    for (int unsigned i = 0; i < NPORTS; i++) begin
      if (rot[i] && !found) begin
        pri[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NPORTS; i++) begin
      gnt[rot_idx(i, ptr)] = pri[i];
    end
  end

  assign valid = |req;

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory master port among NPORTS requesters;
// the owner keeps the bus until its strobes drop.
module mem_rr_arbiter
  import mem_rr_arbiter_pkg::*;
#(
  parameter int unsigned NPORTS = 4,
  parameter int unsigned AW     = MEM_AW,
  parameter int unsigned DW     = MEM_DW
) (
  input  logic              clk,
  input  logic              reset,
  mem_rr_arbiter_if.slave   s,
  mem_rr_arbiter_if.master  m,
  output logic [NPORTS-1:0] grant
);

  localparam int unsigned PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  arb_state_e        state;
  arb_state_e        state_nxt;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     ptr_nxt;
  logic [NPORTS-1:0] grant_nxt;
  logic [NPORTS-1:0] req;
  logic [NPORTS-1:0] pick_gnt;
  logic              pick_valid;
  int unsigned       owner;

  logic [AW-1:0]     mux_address;
  logic [DW-1:0]     mux_writedata;
  logic              mux_write;
  logic              mux_read;
  logic [NPORTS*DW-1:0] back_readdata;
  logic [NPORTS-1:0]    back_waitrequest;

  assign req   = s.read | s.write;
  assign owner = onehot_index(MAX_PORTS'(grant));

  rr_pick #(
    .NPORTS (NPORTS),
    .PW     (PW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // State, pointer and grant registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      grant <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      grant <= grant_nxt;
    end
  end

  // Next state: grant on any request in IDLE, release when the owner drops its strobes.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_nxt = pick_gnt;
          state_nxt = OWNED;
        end
      end
      OWNED: begin
        if ((req & grant) == '0) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          ptr_nxt   = PW'((owner == NPORTS - 1) ? 32'd0 : owner + 32'd1);
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // Outputs: one-hot AND-OR mux from the owner to memory and memory back to the owner.
  always_comb begin
    mux_address      = '0;
    mux_writedata    = '0;
    mux_write        = 1'b0;
    mux_read         = 1'b0;
    back_readdata    = '0;
    back_waitrequest = '1;
    if (state == OWNED) begin
      for (int unsigned i = 0; i < NPORTS; i++) begin
        mux_address   = mux_address   | (s.address[i*AW +: AW]   & {AW{grant[i]}});
        mux_writedata = mux_writedata | (s.writedata[i*DW +: DW] & {DW{grant[i]}});
        mux_write     = mux_write     | (s.write[i] & grant[i]);
        mux_read      = mux_read      | (s.read[i]  & grant[i]);
        back_readdata[i*DW +: DW] = m.readdata & {DW{grant[i]}};
        back_waitrequest[i]       = ~grant[i] | m.waitrequest[0];
      end
    end
  end

  assign m.address     = mux_address;
  assign m.writedata   = mux_writedata;
  assign m.write       = mux_write;
  assign m.read        = mux_read;
  assign s.readdata    = back_readdata;
  assign s.waitrequest = back_waitrequest;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: cycle table for reset/fairness plus
// hand-written read, skip, hold and mid-transfer reset sequences.
module tb_mem_rr_arbiter;

  localparam int unsigned NP = 4;
  localparam int unsigned AW = 18;
  localparam int unsigned DW = 36;

  logic          clk;
  logic          reset;
  logic [NP-1:0] grant;

  mem_rr_arbiter_if #(.N(NP), .AW(AW), .DW(DW)) sif ();
  mem_rr_arbiter_if #(.N(1),  .AW(AW), .DW(DW)) mif ();

  mem_rr_arbiter #(.NPORTS(NP), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .s     (sif),
    .m     (mif),
    .grant (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [NP-1:0] rd;
    logic [NP-1:0] wr;
    logic          mw;
    logic [NP-1:0] eg;
    logic          emr;
    logic          emw;
    logic [NP-1:0] esw;
  } vec_t;

  vec_t tbl [18];
  int total;
  int bad;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // rst, rd, wr, mw | grant, m_read, m_write, s_waitrequest
    tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b1111};
    tbl[1]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b1111};
    tbl[2]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b1111};
    tbl[3]  = '{1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, 4'b1110};
    tbl[4]  = '{1'b0, 4'b1110, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 4'b1111};
    tbl[5]  = '{1'b0, 4'b1110, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b1111};
    tbl[6]  = '{1'b0, 4'b1110, 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b0, 4'b1101};
    tbl[7]  = '{1'b0, 4'b1101, 4'b0000, 1'b1, 4'b0010, 1'b0, 1'b0, 4'b1111};
    tbl[8]  = '{1'b0, 4'b1101, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b1111};
    tbl[9]  = '{1'b0, 4'b1101, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b0, 4'b1011};
    tbl[10] = '{1'b0, 4'b1011, 4'b0000, 1'b1, 4'b0100, 1'b0, 1'b0, 4'b1111};
    tbl[11] = '{1'b0, 4'b1011, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b1111};
    tbl[12] = '{1'b0, 4'b1011, 4'b0000, 1'b0, 4'b1000, 1'b1, 1'b0, 4'b0111};
    tbl[13] = '{1'b0, 4'b0111, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b0, 4'b1111};
    tbl[14] = '{1'b0, 4'b0111, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b1111};
    tbl[15] = '{1'b0, 4'b0111, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b1111};
    tbl[16] = '{1'b1, 4'b0111, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b1111};
    tbl[17] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b1111};

    reset           = 1'b1;
    sif.read        = 4'b1111;
    sif.write       = '0;
    sif.address     = '0;
    sif.writedata   = '0;
    mif.readdata    = '0;
    mif.waitrequest = 1'b1;
    tick();

    // Reset hold, then fairness rotation 0,1,2,3,0 with one idle cycle between owners
    for (int i = 0; i < 18; i++) begin
      reset           = tbl[i].rst;
      sif.read        = tbl[i].rd;
      sif.write       = tbl[i].wr;
      mif.waitrequest = tbl[i].mw;
      #1;
      check($sformatf("tbl%0d_grant", i),  64'(grant),           64'(tbl[i].eg));
      check($sformatf("tbl%0d_mread", i),  64'(mif.read),        64'(tbl[i].emr));
      check($sformatf("tbl%0d_mwrite", i), 64'(mif.write),       64'(tbl[i].emw));
      check($sformatf("tbl%0d_swait", i),  64'(sif.waitrequest), 64'(tbl[i].esw));
      tick();
    end

    // Single read by port 2 with three wait cycles
    sif.address[2*AW +: AW] = 18'o001234;
    sif.read        = 4'b0100;
    mif.waitrequest = 1'b1;
    #1;
    check("rd_pre_mread", 64'(mif.read),    64'(0));
    check("rd_pre_maddr", 64'(mif.address), 64'(0));
    tick();
    check("rd_grant", 64'(grant),           64'(4'b0100));
    check("rd_maddr", 64'(mif.address),     64'(18'o001234));
    check("rd_mread", 64'(mif.read),        64'(1));
    check("rd_swait", 64'(sif.waitrequest), 64'(4'b1111));
    tick();
    tick();
    check("rd_swait_hold", 64'(sif.waitrequest), 64'(4'b1111));
    mif.waitrequest = 1'b0;
    mif.readdata    = 36'o123456701234;
    #1;
    check("rd_data_p2", 64'(sif.readdata[2*DW +: DW]), 64'(36'o123456701234));
    check("rd_data_p0", 64'(sif.readdata[0*DW +: DW]), 64'(0));
    check("rd_ack_swait", 64'(sif.waitrequest), 64'(4'b1011));
    tick();
    sif.read        = '0;
    mif.waitrequest = 1'b1;
    mif.readdata    = '0;
    #1;
    check("rd_drop_mread", 64'(mif.read), 64'(0));
    tick();
    check("rd_idle_grant", 64'(grant), 64'(0));
    tick();

    // ptr=3, only port 1 requests; after release ptr=2 so port 3 beats port 1
    sif.read = 4'b0010;
    tick();
    check("skip_grant1", 64'(grant), 64'(4'b0010));
    sif.read = '0;
    tick();
    check("skip_idle", 64'(grant), 64'(0));
    sif.read = 4'b1010;
    tick();
    check("skip_ptr2_grant3", 64'(grant), 64'(4'b1000));
    sif.read = '0;
    tick();
    tick();

    // Port 1 holds its write strobe over three transfers while port 3 waits
    sif.write = 4'b0010;
    sif.address[1*AW +: AW]   = 18'o000100;
    sif.writedata[1*DW +: DW] = 36'o111111111111;
    tick();
    sif.read = 4'b1000;
    #1;
    check("hold_grant0", 64'(grant),         64'(4'b0010));
    check("hold_mwrite", 64'(mif.write),     64'(1));
    check("hold_maddr0", 64'(mif.address),   64'(18'o000100));
    check("hold_mdata0", 64'(mif.writedata), 64'(36'o111111111111));
    mif.waitrequest = 1'b0;
    #1;
    check("hold_swait", 64'(sif.waitrequest), 64'(4'b1101));
    for (int k = 1; k < 3; k++) begin
      tick();
      sif.address[1*AW +: AW]   = 18'(18'o000100 + k);
      sif.writedata[1*DW +: DW] = 36'(36'o111111111111 * (k + 1));
      #1;
      check($sformatf("hold_grant%0d", k), 64'(grant),         64'(4'b0010));
      check($sformatf("hold_maddr%0d", k), 64'(mif.address),   64'(18'o000100 + k));
      check($sformatf("hold_mdata%0d", k), 64'(mif.writedata), 64'(36'(36'o111111111111 * (k + 1))));
    end
    tick();
    sif.write       = '0;
    mif.waitrequest = 1'b1;
    #1;
    check("hold_drop_grant",  64'(grant),     64'(4'b0010));
    check("hold_drop_mwrite", 64'(mif.write), 64'(0));
    tick();
    check("hold_idle", 64'(grant), 64'(0));
    tick();
    check("hold_next3", 64'(grant),    64'(4'b1000));
    check("hold_next3_rd", 64'(mif.read), 64'(1));
    sif.read = '0;
    tick();
    tick();

    // Reset while port 0 owns the bus mid-write
    sif.write = 4'b0001;
    sif.address[0*AW +: AW] = 18'o007777;
    tick();
    check("rst_mid_grant", 64'(grant),     64'(4'b0001));
    check("rst_mid_mwr",   64'(mif.write), 64'(1));
    reset = 1'b1;
    tick();
    check("rst_after_grant", 64'(grant),           64'(0));
    check("rst_after_mwr",   64'(mif.write),       64'(0));
    check("rst_after_swait", 64'(sif.waitrequest), 64'(4'b1111));
    reset = 1'b0;
    tick();
    check("rst_regrant0", 64'(grant), 64'(4'b0001));
    sif.write = '0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
